carry_lookahead_adder: RTL and testbench



---
 rtl/cla_pkg.sv | 23 ++
 rtl/cla_group4.sv | 44 ++++
 rtl/carry_lookahead_adder.sv | 119 +++++++++++
 tb/tb_carry_lookahead_adder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pkg
//  Description : Shared constants and types for the two-level carry-lookahead
//                adder (group size, default operand width, group GG/GP pair).
//  Revision    : 1.0 - initial release
// ============================================================================
package cla_pkg;

    // Bits per first-level lookahead block
    localparam int GROUP_SIZE        = 4;

    // Datapath width of the RISC core ALU adder
    localparam int CLA_DEFAULT_WIDTH = 32;

    // Group generate / group propagate produced by each 4-bit block
    typedef struct packed {
        logic gg;
        logic gp;
    } group_gp_t;

endpackage : cla_pkg
`default_nettype wire

// File: rtl/cla_group4.sv
`default_nettype none
// ============================================================================
//  Module      : cla_group4
//  Description : 4-bit carry-lookahead block. Internal carries c1..c3 are
//                flattened sum-of-products of the block carry-in, and the
//                block exports group generate (GG) / group propagate (GP)
//                for the second lookahead level.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_group4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_gg,
    output logic       o_gp
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    // Per-bit generate/propagate, lookahead carries and group terms
    always_comb begin
        w_g = i_a & i_b;
        w_p = i_a ^ i_b;

        w_c[0] = i_cin;
        w_c[1] = w_g[0] | (w_p[0] & i_cin);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & i_cin);

        o_sum = w_p ^ w_c;

        // GG/GP do not depend on the carry-in, so the second level never
        // waits on this block's own carry
        o_gg  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
        o_gp  = &w_p;
    end

endmodule : cla_group4
`default_nettype wire

// File: rtl/carry_lookahead_adder.sv
`default_nettype none
// ============================================================================
//  Module      : carry_lookahead_adder
//  Description : Registered WIDTH-bit two-level carry-lookahead adder,
//                {cout, sum} = a + b + cin, captured one clock after
//                in_valid. WIDTH must be a non-zero multiple of 4.
//                Optional feature macro: CLA_OVERFLOW_EN adds the registered
//                signed-overflow output ovf.
//  Revision    : 1.0 - initial release
// ============================================================================
module carry_lookahead_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int c_NUM_GROUPS = WIDTH / GROUP_SIZE;

    group_gp_t [c_NUM_GROUPS-1:0] w_grp;
    logic      [c_NUM_GROUPS:0]   w_blk_c;   // block carry-ins; top entry is cout
    logic      [WIDTH-1:0]        w_sum;
    logic                         w_term;
    logic                         w_acc;

    logic                         r_out_valid;
    logic      [WIDTH-1:0]        r_sum;
    logic                         r_cout;

    // First level: one 4-bit lookahead block per nibble
    generate
        for (genvar k = 0; k < c_NUM_GROUPS; k++) begin : g_group
            cla_group4 u_group (
                .i_a   (a[k*GROUP_SIZE +: GROUP_SIZE]),
                .i_b   (b[k*GROUP_SIZE +: GROUP_SIZE]),
                .i_cin (w_blk_c[k]),
                .o_sum (w_sum[k*GROUP_SIZE +: GROUP_SIZE]),
                .o_gg  (w_grp[k].gg),
                .o_gp  (w_grp[k].gp)
            );
        end
    endgenerate

    // Second level: each block carry-in is the flattened sum-of-products
    // GG[k-1] | GP[k-1]GG[k-2] | ... | GP[k-1..0]cin, so no carry ripples
    // from one block into the next
    always_comb begin
        w_blk_c    = '0;
        w_term     = 1'b0;
        w_acc      = 1'b0;
        w_blk_c[0] = cin;
        for (int k = 1; k <= c_NUM_GROUPS; k++) begin
            w_term = cin;
            for (int j = 0; j < k; j++) begin
                w_term = w_term & w_grp[j].gp;
            end
            w_acc = w_term;
            for (int j = 0; j < k; j++) begin
                w_term = w_grp[j].gg;
                for (int m = j + 1; m < k; m++) begin
                    w_term = w_term & w_grp[m].gp;
                end
                w_acc = w_acc | w_term;
            end
            w_blk_c[k] = w_acc;
        end
    end

    // Result register: capture on in_valid, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
        end else if (in_valid) begin
            r_out_valid <= 1'b1;
            r_sum       <= w_sum;
            r_cout      <= w_blk_c[c_NUM_GROUPS];
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

`ifdef CLA_OVERFLOW_EN
    logic w_c_msb;
    logic r_ovf;

    // Carry into the MSB recovered from its sum bit: c = s ^ a ^ b
    assign w_c_msb = w_sum[WIDTH-1] ^ a[WIDTH-1] ^ b[WIDTH-1];

    // Signed overflow register, updated alongside the sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (in_valid) begin
            r_ovf <= w_c_msb ^ w_blk_c[c_NUM_GROUPS];
        end
    end

    assign ovf = r_ovf;
`endif

endmodule : carry_lookahead_adder
`default_nettype wire

// File: tb/tb_carry_lookahead_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_carry_lookahead_adder
//  Description : Self-checking bench for carry_lookahead_adder (WIDTH=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_carry_lookahead_adder;

    localparam int c_W = 32;

    typedef struct {
        logic [c_W-1:0] a;
        logic [c_W-1:0] b;
        logic           cin;
        logic [c_W-1:0] exp_sum;
        logic           exp_cout;
    } vec_t;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic           cin;
    logic           out_valid;
    logic [c_W-1:0] sum;
    logic           cout;
`ifdef CLA_OVERFLOW_EN
    logic           ovf;
`endif

    int checks;
    int errors;

    carry_lookahead_adder #(.WIDTH(c_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one operand set between edges, then sample 1 time unit after the edge
    task automatic apply(input logic [c_W-1:0] va, input logic [c_W-1:0] vb,
                         input logic vc, input logic vv);
        @(negedge clk);
        a = va; b = vb; cin = vc; in_valid = vv;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[12];

    initial begin
        logic [c_W:0]   ref_full;
        logic [c_W-1:0] ra, rb, hold_sum;
        logic           rc, hold_cout;

        checks = 0; errors = 0;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;

        // Truth table on bit 0, expected value is the plain count a+b+cin
        for (int i = 0; i < 8; i++) begin
            vecs[i].a        = {31'b0, i[2]};
            vecs[i].b        = {31'b0, i[1]};
            vecs[i].cin      = i[0];
            vecs[i].exp_sum  = 32'(i[2]) + 32'(i[1]) + 32'(i[0]);
            vecs[i].exp_cout = 1'b0;
        end
        vecs[8]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vecs[9]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0};
        vecs[10] = '{32'h1234_5678, 32'h8765_4321, 1'b1, 32'h9999_999A, 1'b0};
        vecs[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};

        // Reset state, before any clock activity matters
        #2;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_sum",       64'(sum),       64'd0);
        chk("reset_cout",      64'(cout),      64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1);
            chk($sformatf("vec%0d_sum", i),  64'(sum),       64'(vecs[i].exp_sum));
            chk($sformatf("vec%0d_cout", i), 64'(cout),      64'(vecs[i].exp_cout));
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
        end

        // Hold: in_valid low with new operands leaves the max-case result
        apply(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
        apply(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 1'b0);
        chk("hold_sum",   64'(sum),       64'hFFFF_FFFF);
        chk("hold_cout",  64'(cout),      64'd1);
        chk("hold_valid", 64'(out_valid), 64'd1);

`ifdef CLA_OVERFLOW_EN
        apply(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        chk("ovf1_sum",  64'(sum),  64'h8000_0000);
        chk("ovf1_cout", 64'(cout), 64'd0);
        chk("ovf1_ovf",  64'(ovf),  64'd1);
        apply(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        chk("ovf2_sum",  64'(sum),  64'h0000_0000);
        chk("ovf2_cout", 64'(cout), 64'd1);
        chk("ovf2_ovf",  64'(ovf),  64'd1);
        apply(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b1);
        chk("ovf3_ovf",  64'(ovf),  64'd0);
`endif

        // Asynchronous reset mid-stream, observed before the next edge
        apply(32'h0000_00F0, 32'h0000_000F, 1'b0, 1'b1);
        chk("pre_rst_sum", 64'(sum), 64'h0000_00FF);
        @(negedge clk);
        a = 32'hAAAA_AAAA; b = 32'h5555_5555; cin = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_sum",   64'(sum),       64'd0);
        chk("async_rst_cout",  64'(cout),      64'd0);
`ifdef CLA_OVERFLOW_EN
        chk("async_rst_ovf",   64'(ovf),       64'd0);
`endif
        @(posedge clk);
        #1;
        chk("in_rst_sum", 64'(sum), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // First edge after release captures the held operands
        @(posedge clk);
        #1;
        chk("post_rst_sum",   64'(sum),       64'd0);
        chk("post_rst_cout",  64'(cout),      64'd1);
        chk("post_rst_valid", 64'(out_valid), 64'd1);

        // Random back-to-back stream against an exact wide-integer reference
        for (int n = 0; n < 10000; n++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
            ref_full = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
            apply(ra, rb, rc, 1'b1);
            checks++;
            if (sum !== ref_full[c_W-1:0] || cout !== ref_full[c_W]) begin
                errors++;
                if (errors < 20)
                    $display("FAIL rand%0d: got %h/%b expected %h/%b",
                             n, sum, cout, ref_full[c_W-1:0], ref_full[c_W]);
            end
`ifdef CLA_OVERFLOW_EN
            chk("rand_ovf", 64'(ovf),
                64'((ra[c_W-1] == rb[c_W-1]) && (ref_full[c_W-1] != ra[c_W-1])));
`endif
        end

        // Final hold after the stream
        hold_sum  = sum;
        hold_cout = cout;
        apply(~hold_sum, 32'h1, 1'b1, 1'b0);
        chk("final_hold_sum",  64'(sum),  64'(hold_sum));
        chk("final_hold_cout", 64'(cout), 64'(hold_cout));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_carry_lookahead_adder
`default_nettype wire
